// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the rst_seq_sonata reset sequencer.
//   rst_state_e : sequencer FSM states
//   RstCause*   : bit positions in the sticky reset-cause vector
//   rst_cause_t : reset-cause vector type
//   max3        : helper for deriving counter widths from parameters
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RstAssert,
        RstStretch,
        RstPeriphRel,
        RstRun
    } rst_state_e;

    localparam int unsigned RstCausePor  = 0;
    localparam int unsigned RstCauseLock = 1;
    localparam int unsigned RstCauseBtn  = 2;
    localparam int unsigned RstCauseSw   = 3;

    typedef logic [3:0] rst_cause_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser followed by a debounce filter.
// The output only follows the synchronised input once it has disagreed with the current
// output for DebounceCycles consecutive cycles; any agreeing sample restarts the count.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (flops and output go to ResetVal)
//   din  : asynchronous, possibly bouncy input
//   dout : debounced, synchronous output
module rst_debounce #(
    parameter int unsigned DebounceCycles = 500000,
    parameter bit          ResetVal       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            db_q;
    logic            db_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CntLast) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ResetVal;
            sync2_q <= ResetVal;
            db_q    <= ResetVal;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/rst_seq_sonata.sv
// Reset sequencer for Sonata-class FPGA tops. Merges PLL lock, push-button and software
// reset requests into stretched, staged, registered resets in the clk_sys domain:
// peripherals are released first, the core CoreDelayCycles later. Keeps a sticky
// reset-cause vector for software.
// Ports:
//   clk_sys_i     : system clock
//   rst_sys_i     : synchronous active-high power-on / configuration reset
//   pll_locked_i  : PLL lock, asynchronous
//   btn_rst_ni    : push-button reset, active-low, asynchronous and bouncy
//   sw_rst_req_i  : software reset request, single-cycle synchronous pulse
//   rst_periph_no : peripheral reset, active-low, registered
//   rst_core_no   : core reset, active-low, registered
//   rst_busy_o    : high while the core is held in reset
//   rst_cause_o   : sticky cause {sw, button, lock loss, POR}
module rst_seq_sonata
    import rst_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles  = 500000,
    parameter int unsigned StretchCycles   = 16,
    parameter int unsigned CoreDelayCycles = 16,
    parameter int unsigned CntW            =
        $clog2(max3(DebounceCycles, StretchCycles, CoreDelayCycles) + 1)
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_i,
    input  logic       pll_locked_i,
    input  logic       btn_rst_ni,
    input  logic       sw_rst_req_i,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic       rst_busy_o,
    output rst_cause_t rst_cause_o
);

    localparam logic [CntW-1:0] StretchLast = CntW'(StretchCycles - 1);
    localparam logic [CntW-1:0] CoreLast    = CntW'(CoreDelayCycles - 1);

    // Source vector in cause-bit layout; POR bit is never a live source.
    localparam rst_cause_t SrcResetVal = rst_cause_t'(1) << RstCauseLock;

    logic       lock_sync1_q;
    logic       locked_s;
    logic       btn_db;
    logic       req;
    rst_cause_t src;
    rst_cause_t src_q;

    rst_state_e      state_q;
    rst_state_e      state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            periph_q;
    logic            periph_d;
    logic            core_q;
    logic            core_d;
    rst_cause_t      cause_q;
    rst_cause_t      cause_d;

    // Lock loss must act immediately, so it is only synchronised, never filtered.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            lock_sync1_q <= 1'b0;
            locked_s     <= 1'b0;
        end else begin
            lock_sync1_q <= pll_locked_i;
            locked_s     <= lock_sync1_q;
        end
    end

    rst_debounce #(
        .DebounceCycles (DebounceCycles),
        .ResetVal       (1'b1)
    ) u_btn_debounce (
        .clk  (clk_sys_i),
        .rst  (rst_sys_i),
        .din  (btn_rst_ni),
        .dout (btn_db)
    );

    always_comb begin
        src                = '0;
        src[RstCauseLock]  = ~locked_s;
        src[RstCauseBtn]   = ~btn_db;
        src[RstCauseSw]    = sw_rst_req_i;
    end

    assign req = |src;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        cause_d  = cause_q;

        case (state_q)
            RstAssert: begin
                periph_d = 1'b0;
                core_d   = 1'b0;
                cnt_d    = '0;
                // Only sources that rise while held here are added; levels that were
                // already present (e.g. lock synchroniser coming out of reset) are not.
                cause_d  = cause_q | (src & ~src_q);
                if (!req) begin
                    state_d = RstStretch;
                end
            end
            RstStretch: begin
                if (req) begin
                    state_d = RstAssert;
                    cnt_d   = '0;
                    cause_d = src;
                end else if (cnt_q == StretchLast) begin
                    state_d  = RstPeriphRel;
                    periph_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RstPeriphRel: begin
                // A request wins over the core-release terminal count, so the core can
                // never come out of reset on the same edge the sequence restarts.
                if (req) begin
                    state_d  = RstAssert;
                    periph_d = 1'b0;
                    core_d   = 1'b0;
                    cnt_d    = '0;
                    cause_d  = src;
                end else if (cnt_q == CoreLast) begin
                    state_d = RstRun;
                    core_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RstRun: begin
                if (req) begin
                    state_d  = RstAssert;
                    periph_d = 1'b0;
                    core_d   = 1'b0;
                    cnt_d    = '0;
                    cause_d  = src;
                end
            end
            default: begin
                state_d  = RstAssert;
                periph_d = 1'b0;
                core_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q  <= RstAssert;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            cause_q  <= rst_cause_t'(1) << RstCausePor;
            src_q    <= SrcResetVal;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            cause_q  <= cause_d;
            src_q    <= src;
        end
    end

    assign rst_periph_no = periph_q;
    assign rst_core_no   = core_q;
    assign rst_busy_o    = ~core_q;
    assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_rst_seq_sonata.sv
// Self-checking bench for rst_seq_sonata with DebounceCycles=8, StretchCycles=4,
// CoreDelayCycles=3. Inputs change and outputs are sampled on the falling edge.
// Latencies are counted in rising edges: assert from first stimulus cycle, periph
// release from the assert edge, core release from the periph release edge.
module tb_rst_seq_sonata;

    localparam int Budget = 80;

    logic       clk_sys_i    = 1'b0;
    logic       rst_sys_i    = 1'b1;
    logic       pll_locked_i = 1'b1;
    logic       btn_rst_ni   = 1'b1;
    logic       sw_rst_req_i = 1'b0;
    logic       rst_periph_no;
    logic       rst_core_no;
    logic       rst_busy_o;
    logic [3:0] rst_cause_o;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    typedef struct {
        string      name;
        int         lock_low;   // cycles pll_locked_i held low from k=0
        int         btn_low;    // cycles btn_rst_ni held low from k=0
        int         sw_at;      // cycle of the sw pulse, -1 for none
        int         a;          // expected assert latency, 0 = never, -1 = not checked
        int         p;          // expected periph release latency, 0 = never
        int         c;          // expected core release latency, 0 = never
        logic [3:0] cause;
    } vec_t;

    vec_t vecs[7];
    vec_t exp_q[$];

    rst_seq_sonata #(
        .DebounceCycles  (8),
        .StretchCycles   (4),
        .CoreDelayCycles (3)
    ) dut (
        .clk_sys_i     (clk_sys_i),
        .rst_sys_i     (rst_sys_i),
        .pll_locked_i  (pll_locked_i),
        .btn_rst_ni    (btn_rst_ni),
        .sw_rst_req_i  (sw_rst_req_i),
        .rst_periph_no (rst_periph_no),
        .rst_core_no   (rst_core_no),
        .rst_busy_o    (rst_busy_o),
        .rst_cause_o   (rst_cause_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    // Staged-release and busy invariants, checked every cycle.
    always @(negedge clk_sys_i) begin
        if (rst_core_no === 1'b1 && rst_periph_no !== 1'b1) viol++;
        if (rst_busy_o !== ~rst_core_no) viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pll_locked_i = 1'b1;
        btn_rst_ni   = 1'b1;
        sw_rst_req_i = 1'b0;
    endtask

    task automatic score(input string tag, input int a, input int p, input int c);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
            return;
        end
        e = exp_q.pop_front();
        if (e.a >= 0) check({e.name, "_assert_lat"}, a, e.a);
        check({e.name, "_periph_lat"}, p, e.p);
        check({e.name, "_core_lat"}, c, e.c);
        check({e.name, "_cause"}, {28'b0, rst_cause_o}, {28'b0, e.cause});
    endtask

    // Counts edges from now until periph rises, then until core rises.
    task automatic wait_release(output int p, output int c);
        p = 0;
        c = 0;
        for (int k = 0; k < Budget; k++) begin
            @(negedge clk_sys_i);
            if (p == 0 && rst_periph_no) begin
                p = k + 1;
            end else if (p != 0 && c == 0 && rst_core_no) begin
                c = k + 1 - p;
                break;
            end
        end
    endtask

    task automatic powerup(input string name);
        int p;
        int c;
        exp_q.push_back('{name, 0, 0, -1, -1, 7, 3, 4'b0001});
        rst_sys_i = 1'b0;
        wait_release(p, c);
        score(name, 0, p, c);
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        int p;
        int c;
        exp_q.push_back(v);
        a = 0;
        p = 0;
        c = 0;
        for (int k = 0; k < Budget; k++) begin
            pll_locked_i = !(k < v.lock_low);
            btn_rst_ni   = !(k < v.btn_low);
            sw_rst_req_i = (k == v.sw_at);
            @(negedge clk_sys_i);
            if (a == 0 && !rst_periph_no && !rst_core_no) a = k + 1;
            else if (a != 0 && p == 0 && rst_periph_no) p = k + 1 - a;
            else if (p != 0 && c == 0 && rst_core_no) c = k + 1 - a - p;
            if (c != 0 || (v.a == 0 && k >= 39)) break;
        end
        idle_inputs();
        score(v.name, a, p, c);
    endtask

    initial begin
        int a;
        int p;
        int c;
        int core_seen;

        // Power-on reset values.
        repeat (5) @(negedge clk_sys_i);
        check("reset_periph", {31'b0, rst_periph_no}, 32'd0);
        check("reset_core", {31'b0, rst_core_no}, 32'd0);
        check("reset_busy", {31'b0, rst_busy_o}, 32'd1);
        check("reset_cause", {28'b0, rst_cause_o}, 32'h1);
        powerup("por");

        vecs[0] = '{"sw_pulse",  0, 0,  0,  1,  5, 3, 4'b1000};
        vecs[1] = '{"btn_5",     0, 5,  -1, 0,  0, 0, 4'b1000};
        vecs[2] = '{"btn_7",     0, 7,  -1, 0,  0, 0, 4'b1000};
        vecs[3] = '{"btn_8",     0, 8,  -1, 11, 12, 3, 4'b0100};
        vecs[4] = '{"btn_12",    0, 12, -1, 11, 16, 3, 4'b0100};
        vecs[5] = '{"lock_3",    3, 0,  -1, 3,  7, 3, 4'b0010};
        vecs[6] = '{"lock_sw",   1, 0,  2,  3,  5, 3, 4'b1010};
        foreach (vecs[i]) run_vec(vecs[i]);

        // Lock glitch in PERIPH_REL, timed to land on the core-release edge.
        exp_q.push_back('{"glitch_restart", 0, 0, -1, 3, 5, 3, 4'b0010});
        sw_rst_req_i = 1'b1;
        @(negedge clk_sys_i);
        sw_rst_req_i = 1'b0;
        p = 0;
        for (int k = 0; k < 20; k++) begin
            if (rst_periph_no) break;
            @(negedge clk_sys_i);
            p = k + 1;
        end
        check("glitch_periph_lat", p, 5);
        pll_locked_i = 1'b0;
        a = 0;
        core_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys_i);
            pll_locked_i = 1'b1;
            if (rst_core_no) core_seen++;
            if (!rst_periph_no && !rst_core_no) begin
                a = k + 1;
                break;
            end
        end
        check("glitch_core_never_high", core_seen, 0);
        wait_release(p, c);
        score("glitch_restart", a, p, c);

        // rst_sys_i asserted while in STRETCH.
        sw_rst_req_i = 1'b1;
        @(negedge clk_sys_i);
        sw_rst_req_i = 1'b0;
        repeat (2) @(negedge clk_sys_i);
        check("mid_pre_cause", {28'b0, rst_cause_o}, 32'h8);
        rst_sys_i = 1'b1;
        @(negedge clk_sys_i);
        check("mid_periph", {31'b0, rst_periph_no}, 32'd0);
        check("mid_core", {31'b0, rst_core_no}, 32'd0);
        check("mid_busy", {31'b0, rst_busy_o}, 32'd1);
        check("mid_cause", {28'b0, rst_cause_o}, 32'h1);
        powerup("mid_por");

        check("invariant_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
